// File: rtl/song_pkg.sv
`default_nettype none
// ==========================================================================
// song_pkg : shared state encodings and default widths for the sequencer
// Rev 1.0
// ==========================================================================
package song_pkg;

  localparam int c_ADDR_W = 5;
  localparam int c_SONG_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/song_address_sequencer_if.sv
`default_nettype none
// ==========================================================================
// song_address_sequencer_if : control/status bundle between player and ROM
// Rev 1.0
// ==========================================================================
interface song_address_sequencer_if #(
  parameter int ADDR_W = song_pkg::c_ADDR_W,
  parameter int SONG_W = song_pkg::c_SONG_W
);

  logic                     play;
  logic                     restart;
  logic                     note_done;
  logic                     loop_en;
  logic [SONG_W-1:0]        song_sel;
  logic [ADDR_W-1:0]        song_last;
  logic [SONG_W+ADDR_W-1:0] note_addr;
  logic                     playing;
  logic                     song_done;
  logic [1:0]               state;

  modport master (
    output play, restart, note_done, loop_en, song_sel, song_last,
    input  note_addr, playing, song_done, state
  );

  modport slave (
    input  play, restart, note_done, loop_en, song_sel, song_last,
    output note_addr, playing, song_done, state
  );

endinterface
`default_nettype wire

// File: rtl/note_index_counter.sv
`default_nettype none
// ==========================================================================
// note_index_counter : note index within a song, wraps after the last note
// Rev 1.0
// ==========================================================================
module note_index_counter
  import song_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              clear,
  input  wire logic              load,
  input  wire logic              enable,
  input  wire logic [ADDR_W-1:0] last,
  output logic      [ADDR_W-1:0] idx,
  output logic                   at_last
);

  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_last;
  logic              w_at_last;

  assign w_at_last = (r_idx == r_last);

  // Wrap is an explicit compare, so a full-range song never relies on overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= '0;
      r_last <= '0;
    end else if (load) begin
      r_idx  <= '0;
      r_last <= last;
    end else if (clear) begin
      r_idx  <= '0;
    end else if (enable) begin
      r_idx  <= w_at_last ? '0 : r_idx + 1'b1;
    end
  end

  assign idx     = r_idx;
  assign at_last = w_at_last;

endmodule
`default_nettype wire

// File: rtl/song_address_sequencer.sv
`default_nettype none
// ==========================================================================
// song_address_sequencer : play/pause/loop FSM producing note ROM addresses
// Rev 1.0
// ==========================================================================
module song_address_sequencer
  import song_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int SONG_W = c_SONG_W
) (
  input wire logic                 clk,
  input wire logic                 reset,
  song_address_sequencer_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic [SONG_W-1:0] r_song;
  logic [ADDR_W-1:0] w_idx;
  logic              w_at_last;
  logic              w_load;
  logic              w_clear;
  logic              w_enable;
  logic              w_song_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_song  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_song <= bus.song_sel;
      end
    end
  end

  // restart outranks note_done and play everywhere except IDLE.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_enable    = 1'b0;
    w_song_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (bus.play) begin
          w_load = 1'b1;
          w_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.restart) begin
          w_load = 1'b1;
        end else begin
          if (bus.note_done) begin
            w_enable = 1'b1;
            if (w_at_last) begin
              w_song_done = 1'b1;
              if (!bus.loop_en) begin
                w_next = ST_DONE;
              end
            end
          end
          if (w_next == ST_PLAY && !bus.play) begin
            w_next = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.restart) begin
          w_load = 1'b1;
          w_next = ST_PLAY;
        end else if (bus.play) begin
          w_next = ST_PLAY;
        end
      end
      ST_DONE: begin
        w_clear = 1'b1;
        if (bus.restart) begin
          w_load = 1'b1;
          w_next = ST_PLAY;
        end else if (!bus.play) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  note_index_counter #(
    .ADDR_W (ADDR_W)
  ) u_note_index_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .load    (w_load),
    .enable  (w_enable),
    .last    (bus.song_last),
    .idx     (w_idx),
    .at_last (w_at_last)
  );

  assign bus.note_addr = {r_song, w_idx};
  assign bus.playing   = (r_state == ST_PLAY);
  assign bus.song_done = w_song_done;
  assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_song_address_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_song_address_sequencer : directed scenarios plus random run vs. model
// Rev 1.0
// ==========================================================================
module tb_song_address_sequencer;

  localparam int c_ADDR_W = 5;
  localparam int c_SONG_W = 2;

  logic clk = 1'b0;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: song number, last note, current note, state code.
  int m_st, m_song, m_last, m_idx;

  logic [6:0] s_addr, e_addr;
  logic       s_sd, e_sd, s_playing, e_playing;
  logic [1:0] s_state, e_state;

  song_address_sequencer_if #(.ADDR_W(c_ADDR_W), .SONG_W(c_SONG_W)) bus ();

  song_address_sequencer #(.ADDR_W(c_ADDR_W), .SONG_W(c_SONG_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_st = 0; m_song = 0; m_last = 0; m_idx = 0;
  endtask

  task automatic model_update();
    if (bus.restart && m_st != 0) begin
      m_song = int'(bus.song_sel); m_last = int'(bus.song_last); m_idx = 0; m_st = 1;
    end else if (m_st == 0) begin
      if (bus.play) begin
        m_song = int'(bus.song_sel); m_last = int'(bus.song_last); m_idx = 0; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (bus.note_done) begin
        if (m_idx == m_last && !bus.loop_en) m_st = 3;
        m_idx = (m_idx + 1) % (m_last + 1);
      end
      if (m_st == 1 && !bus.play) m_st = 2;
    end else if (m_st == 2) begin
      if (bus.play) m_st = 1;
    end else begin
      if (!bus.play) m_st = 0;
    end
  endtask

  // Called at posedge+1 with inputs set; samples mid-cycle, then advances one edge.
  task automatic step();
    @(negedge clk);
    s_addr    = bus.note_addr;
    s_sd      = bus.song_done;
    s_state   = bus.state;
    s_playing = bus.playing;
    e_addr    = 7'((m_song << c_ADDR_W) | m_idx);
    e_sd      = (m_st == 1) && bus.note_done && (m_idx == m_last) && !bus.restart;
    e_state   = 2'(m_st);
    e_playing = (m_st == 1);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.play = 0; bus.restart = 0; bus.note_done = 0; bus.loop_en = 0;
    bus.song_sel = 0; bus.song_last = 0;
    model_reset();
    #12;
    vectors++; if (bus.note_addr !== 7'h00) begin miscompares++; $display("FAIL reset_addr got %h exp 00", bus.note_addr); end
    vectors++; if (bus.playing !== 1'b0) begin miscompares++; $display("FAIL reset_playing got %b exp 0", bus.playing); end
    vectors++; if (bus.song_done !== 1'b0) begin miscompares++; $display("FAIL reset_song_done got %b exp 0", bus.song_done); end
    vectors++; if (bus.state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", bus.state); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    step();
    vectors++; if (s_state !== 2'd0) begin miscompares++; $display("FAIL idle_hold got %0d exp 0", s_state); end
  endtask

  task automatic test_single_song();
    bus.song_sel = 2'd2; bus.song_last = 5'd3; bus.loop_en = 0; bus.play = 1;
    step();
    vectors++; if (bus.state !== 2'd1 || bus.note_addr !== 7'h40) begin miscompares++; $display("FAIL start got st=%0d addr=%h exp st=1 addr=40", bus.state, bus.note_addr); end
    for (int k = 0; k < 4; k++) begin
      bus.note_done = 1; step();
      vectors++; if (s_addr !== 7'(8'h40 + k)) begin miscompares++; $display("FAIL single_addr[%0d] got %h exp %h", k, s_addr, 8'h40 + k); end
      vectors++; if (s_sd !== (k == 3)) begin miscompares++; $display("FAIL single_done[%0d] got %b exp %b", k, s_sd, k == 3); end
    end
    bus.note_done = 0;
    vectors++; if (bus.state !== 2'd3 || bus.note_addr !== 7'h40) begin miscompares++; $display("FAIL single_end got st=%0d addr=%h exp st=3 addr=40", bus.state, bus.note_addr); end
    step();
    vectors++; if (bus.state !== 2'd3) begin miscompares++; $display("FAIL done_hold got %0d exp 3", bus.state); end
  endtask

  task automatic test_loop();
    bus.play = 0; step();
    vectors++; if (bus.state !== 2'd0) begin miscompares++; $display("FAIL done_to_idle got %0d exp 0", bus.state); end
    bus.loop_en = 1; bus.play = 1; step();
    for (int k = 0; k < 9; k++) begin
      bus.note_done = 1; step();
      vectors++; if (s_sd !== (k == 3 || k == 7)) begin miscompares++; $display("FAIL loop_done[%0d] got %b exp %b", k, s_sd, (k == 3 || k == 7)); end
    end
    bus.note_done = 0;
    vectors++; if (bus.state !== 2'd1 || bus.note_addr !== 7'h41) begin miscompares++; $display("FAIL loop_end got st=%0d addr=%h exp st=1 addr=41", bus.state, bus.note_addr); end
  endtask

  task automatic test_pause();
    bus.restart = 1; step(); bus.restart = 0;
    bus.note_done = 1; step(); step();
    bus.note_done = 0; bus.play = 0; step();
    vectors++; if (bus.state !== 2'd2 || bus.note_addr !== 7'h42) begin miscompares++; $display("FAIL pause_enter got st=%0d addr=%h exp st=2 addr=42", bus.state, bus.note_addr); end
    for (int k = 0; k < 3; k++) begin
      bus.note_done = 1; step();
      vectors++; if (s_addr !== 7'h42 || s_state !== 2'd2 || s_sd !== 1'b0) begin miscompares++; $display("FAIL pause_hold[%0d] got addr=%h st=%0d sd=%b exp 42/2/0", k, s_addr, s_state, s_sd); end
    end
    vectors++; if (bus.note_addr !== 7'h42) begin miscompares++; $display("FAIL pause_after got %h exp 42", bus.note_addr); end
    bus.note_done = 0; bus.play = 1; step();
    vectors++; if (bus.state !== 2'd1 || bus.note_addr !== 7'h42) begin miscompares++; $display("FAIL resume got st=%0d addr=%h exp st=1 addr=42", bus.state, bus.note_addr); end
    bus.note_done = 1; step(); bus.note_done = 0;
    vectors++; if (bus.note_addr !== 7'h43) begin miscompares++; $display("FAIL resume_inc got %h exp 43", bus.note_addr); end
  endtask

  task automatic test_restart_collision();
    bus.loop_en = 0; bus.song_sel = 2'd1; bus.restart = 1; bus.note_done = 1;
    step();
    bus.restart = 0; bus.note_done = 0;
    vectors++; if (s_sd !== 1'b0) begin miscompares++; $display("FAIL restart_sd got %b exp 0", s_sd); end
    vectors++; if (bus.note_addr !== 7'h20 || bus.state !== 2'd1) begin miscompares++; $display("FAIL restart got addr=%h st=%0d exp addr=20 st=1", bus.note_addr, bus.state); end
    bus.song_sel = 2'd3; bus.song_last = 5'd0; bus.note_done = 1; step(); bus.note_done = 0;
    vectors++; if (bus.note_addr !== 7'h21 || bus.state !== 2'd1) begin miscompares++; $display("FAIL no_reload got addr=%h st=%0d exp addr=21 st=1", bus.note_addr, bus.state); end
  endtask

  task automatic test_async_reset();
    bus.song_sel = 2'd1; bus.song_last = 5'd10; bus.restart = 1; step(); bus.restart = 0;
    bus.note_done = 1; repeat (5) step(); bus.note_done = 0;
    vectors++; if (bus.note_addr !== 7'h25) begin miscompares++; $display("FAIL pre_reset got %h exp 25", bus.note_addr); end
    #2; reset = 1'b1; bus.note_done = 1; #1;
    vectors++; if (bus.note_addr !== 7'h00 || bus.playing !== 1'b0 || bus.song_done !== 1'b0 || bus.state !== 2'd0) begin
      miscompares++; $display("FAIL async_reset got addr=%h pl=%b sd=%b st=%0d exp all 0", bus.note_addr, bus.playing, bus.song_done, bus.state); end
    bus.note_done = 0; bus.play = 0;
    @(posedge clk); #3; reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (s_state !== 2'd0) begin miscompares++; $display("FAIL post_reset_idle[%0d] got %0d exp 0", k, s_state); end
    end
    bus.play = 1; step();
    vectors++; if (bus.state !== 2'd1 || bus.note_addr !== 7'h20) begin miscompares++; $display("FAIL post_reset_start got st=%0d addr=%h exp st=1 addr=20", bus.state, bus.note_addr); end
  endtask

  task automatic test_boundaries();
    bus.song_sel = 2'd3; bus.song_last = 5'd0; bus.loop_en = 1; bus.restart = 1; step(); bus.restart = 0;
    for (int k = 0; k < 2; k++) begin
      bus.note_done = 1; step();
      vectors++; if (s_sd !== 1'b1 || s_addr !== 7'h60) begin miscompares++; $display("FAIL one_note[%0d] got sd=%b addr=%h exp 1/60", k, s_sd, s_addr); end
    end
    bus.note_done = 0;
    bus.song_sel = 2'd2; bus.song_last = 5'd31; bus.restart = 1; step(); bus.restart = 0;
    bus.note_done = 1;
    for (int k = 0; k < 31; k++) begin
      step();
      vectors++; if (s_sd !== 1'b0) begin miscompares++; $display("FAIL full_early_done[%0d] got 1 exp 0", k); end
    end
    vectors++; if (bus.note_addr !== 7'h5F) begin miscompares++; $display("FAIL full_last got %h exp 5f", bus.note_addr); end
    step(); bus.note_done = 0;
    vectors++; if (s_sd !== 1'b1) begin miscompares++; $display("FAIL full_done got %b exp 1", s_sd); end
    vectors++; if (bus.note_addr !== 7'h40 || bus.state !== 2'd1) begin miscompares++; $display("FAIL full_wrap got addr=%h st=%0d exp addr=40 st=1", bus.note_addr, bus.state); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      bus.play      = ($urandom_range(0, 7) != 0);
      bus.restart   = ($urandom_range(0, 15) == 0);
      bus.note_done = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 31) == 0) bus.loop_en = ~bus.loop_en;
      bus.song_sel  = 2'($urandom);
      bus.song_last = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      step();
      vectors++; if (s_addr !== e_addr) begin miscompares++; $display("FAIL rand_addr[%0d] got %h exp %h", n, s_addr, e_addr); end
      vectors++; if (s_sd !== e_sd) begin miscompares++; $display("FAIL rand_done[%0d] got %b exp %b", n, s_sd, e_sd); end
      vectors++; if (s_state !== e_state) begin miscompares++; $display("FAIL rand_state[%0d] got %0d exp %0d", n, s_state, e_state); end
      vectors++; if (s_playing !== e_playing) begin miscompares++; $display("FAIL rand_playing[%0d] got %b exp %b", n, s_playing, e_playing); end
    end
    bus.restart = 0; bus.note_done = 0;
  endtask

  initial begin
    test_reset();
    test_single_song();
    test_loop();
    test_pause();
    test_restart_collision();
    test_async_reset();
    test_boundaries();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/song_address_sequencer.md
SONG_ADDRESS_SEQUENCER -- requirements
Module: song_address_sequencer

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the note-index width (up to 2^ADDR_W notes per song).
REQ-002 Parameter SONG_W, default 2, SHALL set the song-select width (2^SONG_W songs).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 play  input  1  level; 1 = run or resume, 0 = pause or stop.
REQ-006 restart  input  1  single-cycle pulse; returns to note 0 of the currently selected song.
REQ-007 note_done  input  1  single-cycle pulse from the note player marking the end of the current note.
REQ-008 loop_en  input  1  level; 1 = wrap to note 0 at end of song, 0 = stop.
REQ-009 song_sel  input  SONG_W  song to load on start or restart.
REQ-010 song_last  input  ADDR_W  index of the last note of the song to load.
REQ-011 note_addr  output  SONG_W+ADDR_W  ROM address {song_q, idx_q}.
REQ-012 playing  output  1  high only in state PLAY.
REQ-013 song_done  output  1  combinational end-of-song pulse.
REQ-014 state  output  2  current FSM state code, for debug.

Function
REQ-015 The FSM SHALL have four states: IDLE=0, PLAY=1, PAUSE=2, DONE=3.
REQ-016 IDLE with play=1: next state PLAY, with song_q<=song_sel, last_q<=song_last, idx_q<=0.
REQ-017 PLAY with note_done=1 and idx_q!=last_q: idx_q SHALL increment by 1, with no other change.
REQ-018 PLAY with note_done=1 and idx_q==last_q: idx_q<=0; next state PLAY if loop_en=1, else DONE.
REQ-019 song_done SHALL equal (state==PLAY && note_done && idx_q==last_q && !restart), with zero latency, in the same cycle as the final note_done.
REQ-020 PLAY with play=0 and no note_done: next state PAUSE; idx_q holds. If note_done arrives in the same cycle, REQ-017/018 apply first and the next state is still PAUSE, unless REQ-018 selects DONE.
REQ-021 PAUSE: note_done SHALL be ignored; play=1 returns to PLAY without reloading song_q or last_q.
REQ-022 DONE: idx_q=0 and note_done is ignored; play=0 goes to IDLE, so a new start needs play to fall and rise again.
REQ-023 restart=1 in PLAY, PAUSE or DONE: idx_q<=0, reload song_q and last_q from the inputs, next state PLAY. restart takes priority over note_done and play.
REQ-024 restart=1 in IDLE SHALL be ignored.
REQ-025 Changes on song_sel and song_last outside a load event (REQ-016/023) SHALL have no effect.
REQ-026 song_last=0 SHALL give a one-note song: the first note_done raises song_done.
REQ-027 song_last=2^ADDR_W-1 SHALL wrap idx_q to 0 without overflow into song_q.

Reset
REQ-028 While reset=1, asynchronously: state=IDLE, idx_q=0, song_q=0, last_q=0; hence note_addr=0, playing=0, song_done=0.
REQ-029 Reset asserted mid-song SHALL abandon the song; after release the block waits in IDLE for play=1.

Structure
REQ-030 State encodings and default widths SHALL live in shared package song_pkg.
REQ-031 Note indexing SHALL be implemented as one sub-module, note_index_counter, with inputs clear, load, enable and last, and outputs idx and at_last.

Verification
REQ-032 Defaults, song_sel=2, song_last=3, loop_en=0, play=1, then 4 note_done pulses -> note_addr 0x40..0x43, song_done high exactly on the 4th pulse, state DONE, note_addr 0x40.
REQ-033 Same setup with loop_en=1 and 9 pulses -> song_done pulses on the 4th and 8th pulses, final note_addr 0x41, state PLAY.
REQ-034 Pause at idx 2, apply 3 note_done pulses, then set play=1 -> idx stays 2 throughout the pause and increments on the next pulse.
REQ-035 restart and note_done asserted together at idx 3 with song_sel changed to 1 -> note_addr 0x20, song_done 0, state PLAY.
REQ-036 Reset asserted asynchronously between clock edges at idx 5 -> all outputs 0 immediately; the block stays in IDLE until play rises.
REQ-037 song_last=0 and song_last=31 cases -> single-pulse song_done, and a clean 31->0 wrap.
